jogo_sequencia_param: RTL and testbench
=======================================

// Module: jogo_sequencia_param
// PURPOSE
// - Parametrised successor of the memory-game engine: N_BOTOES buttons/LEDs, growing sequence up to MAX_RODADAS.
// - Each round it plays the stored sequence on leds, then checks player presses element by element.
// - It appends one LFSR-generated element per won round and enforces a per-press timeout.
// - Replaces the fixed 4-button datapath/control pair with one self-contained core; top-level drives 7-seg from db_*.
// PARAMETERS
// - N_BOTOES       default 4      number of buttons/LEDs (2..16); W = clog2(N_BOTOES)
// - MAX_RODADAS    default 16     rounds needed to win at nivel_jogadas=1 (even, 2..64)
// - TIMEOUT_CICLOS default 5000   cycles allowed per press at nivel_tempo=0
// - SHOW_CICLOS    default 1000   cycles each sequence LED is lit
// - GAP_CICLOS     default 250    dark cycles between shown elements
// - SEMENTE        default 8'hA5  non-zero reset value of the 8-bit LFSR
// PORTS
// - clock          in   1         system clock, rising edge
// - reset          in   1         asynchronous, active-low; clears all state
// - iniciar        in   1         level; sampled in INICIAL and FIM_* states
// - chaves         in   N_BOTOES  raw button levels, pre-synchronised
// - nivel_jogadas  in   1         0: MAX_RODADAS/2 rounds, 1: MAX_RODADAS rounds
// - nivel_tempo    in   1         0: TIMEOUT_CICLOS, 1: TIMEOUT_CICLOS/2
// - leds           out  N_BOTOES  one-hot LED drive; registered
// - acertou/errou/timeout out 1   game result flags, held until next start or reset
// - pronto         out  1         high in any FIM_* state
// - db_estado      out  4         current state code
// - db_rodada      out  6         current round index, 0-based
// - db_contagem    out  6         element index within the round
// - db_jogada      out  W         last decoded press
// BEHAVIOUR
// - Reset: state INICIAL, all outputs 0, round/index/counters 0, LFSR = SEMENTE.
// - LFSR: 8-bit x^8+x^6+x^5+x^4+1, steps every cycle; new element = lfsr mod N_BOTOES.
// - Levels latch in PREPARA; mid-game level changes are ignored.
// - State codes: INICIAL=0, PREPARA=1, MOSTRA=2, INTERVALO=3, ESPERA=4, REGISTRA=5, COMPARA=6, PROXIMO=7, NOVA_RODADA=8.
// - State codes (cont.): FIM_ACERTO=A, FIM_ERRO=E, FIM_TIMEOUT=F.
// - INICIAL --iniciar--> PREPARA. PREPARA: clears flags, round=0, idx=0, writes mem[0]. Next state MOSTRA.
// - MOSTRA: leds=onehot(mem[idx]) for SHOW_CICLOS cycles, then INTERVALO with leds=0 for GAP_CICLOS cycles.
// - INTERVALO exit: if idx==round, idx=0 and go to ESPERA; otherwise idx+1 and return to MOSTRA.
// - ESPERA: timeout counter runs; a press is a 0->non-zero transition of chaves (sub-module).
// - Press -> REGISTRA: latches the press and resets the timer; leds mirror chaves while held.
// - Counter reaching limit-1 with no press -> FIM_TIMEOUT.
// - REGISTRA -> COMPARA (1 cycle). A non-one-hot press counts as wrong.
// - COMPARA, wrong -> FIM_ERRO. Right and idx<round -> PROXIMO (idx+1) -> ESPERA.
// - COMPARA, right and idx==round: round==limit-1 -> FIM_ACERTO; otherwise NOVA_RODADA.
// - NOVA_RODADA: round+1, mem[round+1]=new element, idx=0, then MOSTRA.
// - Press-to-verdict latency: 2 cycles after the detected edge.
// - Press and timeout in the same cycle: press wins.
// - Presses during MOSTRA/INTERVALO are ignored; the edge detector still tracks chaves, so a held key is not a press later.
// - FIM_*: flag held, pronto=1. iniciar -> PREPARA with the sequence regenerated from the current LFSR state.
// - Reset mid-game: immediate return to INICIAL with outputs cleared.
// STRUCTURE
// - Package jogo_pkg: state encoding localparams and the LFSR tap constant.
// - Package also holds onehot/clog2 helper functions.
// - Sub-module detector_jogada: registers chaves and emits a 1-cycle pulse plus binary index and onehot_ok.
// - Sequence memory is an internal MAX_RODADAS x W register array; timers are internal counters.
// TESTING
// - Win: MAX=4, nivel_jogadas=0, correct presses each round -> acertou=1, pronto=1, db_estado=A after round 1.
// - Error: round 0 with a press different from the shown LED -> errou=1, db_estado=E 2 cycles after the edge.
// - Timeout: nivel_tempo=1, no press for TIMEOUT/2 cycles in ESPERA -> timeout=1, db_estado=F.
// - Timeout with nivel_tempo=0: no timeout at TIMEOUT/2 cycles.
// - Invalid press: chaves=4'b0011 -> errou=1. A key held from MOSTRA into ESPERA gives no press.
// - Display: each element shows exactly SHOW_CICLOS cycles, then GAP_CICLOS dark; round r shows r+1 elements.
// - Reset asserted in MOSTRA -> leds=0 and db_estado=0 asynchronously; iniciar restarts at round 0.

Source files
------------

// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - state encoding, LFSR taps and helper functions for the memory game core
package jogo_pkg;

    // Fixed codes so db_estado can drive a hex 7-segment digit directly.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        MOSTRA      = 4'h2,
        INTERVALO   = 4'h3,
        ESPERA      = 4'h4,
        REGISTRA    = 4'h5,
        COMPARA     = 4'h6,
        PROXIMO     = 4'h7,
        NOVA_RODADA = 4'h8,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hE,
        FIM_TIMEOUT = 4'hF
    } estado_t;

    // x^8 + x^6 + x^5 + x^4 + 1 : feedback taps on bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Ceiling log2, never below 1 so a width derived from it is always legal.
    function automatic int clog2(input int valor);
        int r;
        int v;
        r = 0;
        v = valor - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // One-hot decode of a button index (up to 16 buttons).
    function automatic logic [15:0] onehot(input logic [3:0] indice);
        return 16'h0001 << indice;
    endfunction

    // One Fibonacci LFSR step: shift left, feedback enters at bit 0.
    function automatic logic [7:0] lfsr_passo(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - press edge detector and button index decoder
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   chaves            raw button levels (already synchronised)
//   pulso             high in the cycle chaves goes from all-zero to non-zero
//   indice            binary index of the lowest pressed button
//   onehot_ok         exactly one button is pressed
module detector_jogada #(
    parameter int N_BOTOES = 4,
    parameter int W        = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] chaves,
    output logic                pulso,
    output logic [W-1:0]        indice,
    output logic                onehot_ok
);

    logic [N_BOTOES-1:0] chaves_q;

    // Tracks chaves every cycle regardless of the game state, so a key
    // already held when the core starts listening never counts as a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chaves_q <= '0;
        end else begin
            chaves_q <= chaves;
        end
    end

    // Combinational so the press is accepted on the same edge it is seen.
    assign pulso = (chaves_q == '0) && (chaves != '0);

    always_comb begin
        indice = '0;
        for (int i = N_BOTOES - 1; i >= 0; i--) begin
            if (chaves[i]) begin
                indice = W'(i);
            end
        end
    end

    assign onehot_ok = (chaves != '0) && ((chaves & (chaves - N_BOTOES'(1))) == '0);

endmodule

// File: rtl/jogo_sequencia_param.sv
// rtl/jogo_sequencia_param.sv - parametrised memory game core: show sequence, check presses, grow per round
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-low reset
//   iniciar                       start/restart level, sampled in INICIAL and FIM_*
//   chaves                        button levels
//   nivel_jogadas, nivel_tempo    difficulty levels, latched in PREPARA
//   leds                          registered LED drive (sequence or mirrored buttons)
//   acertou, errou, timeout       result flags, held until the next start
//   pronto                        high in any FIM_* state
//   db_estado/db_rodada/db_contagem/db_jogada   debug: state, round, element index, last press
module jogo_sequencia_param
    import jogo_pkg::*;
#(
    parameter int         N_BOTOES       = 4,
    parameter int         MAX_RODADAS    = 16,
    parameter int         TIMEOUT_CICLOS = 5000,
    parameter int         SHOW_CICLOS    = 1000,
    parameter int         GAP_CICLOS     = 250,
    parameter logic [7:0] SEMENTE        = 8'hA5,
    localparam int        W              = clog2(N_BOTOES)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [N_BOTOES-1:0] chaves,
    input  logic                nivel_jogadas,
    input  logic                nivel_tempo,
    output logic [N_BOTOES-1:0] leds,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic                pronto,
    output logic [3:0]          db_estado,
    output logic [5:0]          db_rodada,
    output logic [5:0]          db_contagem,
    output logic [W-1:0]        db_jogada
);

    localparam int RW    = clog2(MAX_RODADAS);
    localparam int T_MAX = (TIMEOUT_CICLOS > SHOW_CICLOS)
                         ? ((TIMEOUT_CICLOS > GAP_CICLOS) ? TIMEOUT_CICLOS : GAP_CICLOS)
                         : ((SHOW_CICLOS > GAP_CICLOS) ? SHOW_CICLOS : GAP_CICLOS);
    localparam int TW    = clog2(T_MAX + 1);

    estado_t             estado, estado_n;
    logic [5:0]          rodada, rodada_n;
    logic [5:0]          idx, idx_n;
    logic [TW-1:0]       timer, timer_n;
    logic [7:0]          lfsr;
    logic [W-1:0]        mem [MAX_RODADAS];
    logic                nj_q, nj_n, nt_q, nt_n;
    logic [W-1:0]        jogada_q, jogada_n;
    logic                ok_q, ok_n;
    logic                acertou_q, acertou_n;
    logic                errou_q, errou_n;
    logic                timeout_q, timeout_n;
    logic [N_BOTOES-1:0] leds_q, leds_n;
    logic                mem_we;
    logic [RW-1:0]       mem_waddr;
    logic [W-1:0]        novo_elemento;
    logic [W-1:0]        mem_rd_n;
    logic [5:0]          ultima_rodada;
    logic [TW-1:0]       ultimo_tick;
    logic                pulso, onehot_ok;
    logic [W-1:0]        indice;

    detector_jogada #(
        .N_BOTOES (N_BOTOES),
        .W        (W)
    ) u_detector (
        .clock     (clock),
        .reset     (reset),
        .chaves    (chaves),
        .pulso     (pulso),
        .indice    (indice),
        .onehot_ok (onehot_ok)
    );

    assign novo_elemento = W'(lfsr % 8'(N_BOTOES));
    assign ultima_rodada = nj_q ? 6'(MAX_RODADAS - 1) : 6'(MAX_RODADAS / 2 - 1);
    assign ultimo_tick   = nt_q ? TW'(TIMEOUT_CICLOS / 2 - 1) : TW'(TIMEOUT_CICLOS - 1);

    always_comb begin
        estado_n  = estado;
        rodada_n  = rodada;
        idx_n     = idx;
        timer_n   = timer;
        nj_n      = nj_q;
        nt_n      = nt_q;
        jogada_n  = jogada_q;
        ok_n      = ok_q;
        acertou_n = acertou_q;
        errou_n   = errou_q;
        timeout_n = timeout_q;
        mem_we    = 1'b0;
        mem_waddr = '0;

        case (estado)
            INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) begin
                    estado_n = PREPARA;
                end
            end
            PREPARA: begin
                acertou_n = 1'b0;
                errou_n   = 1'b0;
                timeout_n = 1'b0;
                rodada_n  = '0;
                idx_n     = '0;
                timer_n   = '0;
                nj_n      = nivel_jogadas;
                nt_n      = nivel_tempo;
                mem_we    = 1'b1;
                mem_waddr = '0;
                estado_n  = MOSTRA;
            end
            MOSTRA: begin
                if (timer == TW'(SHOW_CICLOS - 1)) begin
                    timer_n  = '0;
                    estado_n = INTERVALO;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            INTERVALO: begin
                if (timer == TW'(GAP_CICLOS - 1)) begin
                    timer_n = '0;
                    if (idx == rodada) begin
                        idx_n    = '0;
                        estado_n = ESPERA;
                    end else begin
                        idx_n    = idx + 6'd1;
                        estado_n = MOSTRA;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ESPERA: begin
                // A press on the final tick still wins over the timeout.
                if (pulso) begin
                    jogada_n = indice;
                    ok_n     = onehot_ok;
                    timer_n  = '0;
                    estado_n = REGISTRA;
                end else if (timer == ultimo_tick) begin
                    timer_n   = '0;
                    timeout_n = 1'b1;
                    estado_n  = FIM_TIMEOUT;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            REGISTRA: begin
                estado_n = COMPARA;
            end
            COMPARA: begin
                if (!ok_q || (jogada_q != mem[RW'(idx)])) begin
                    errou_n  = 1'b1;
                    estado_n = FIM_ERRO;
                end else if (idx != rodada) begin
                    estado_n = PROXIMO;
                end else if (rodada == ultima_rodada) begin
                    acertou_n = 1'b1;
                    estado_n  = FIM_ACERTO;
                end else begin
                    estado_n = NOVA_RODADA;
                end
            end
            PROXIMO: begin
                idx_n    = idx + 6'd1;
                timer_n  = '0;
                estado_n = ESPERA;
            end
            NOVA_RODADA: begin
                rodada_n  = rodada + 6'd1;
                mem_we    = 1'b1;
                mem_waddr = RW'(rodada + 6'd1);
                idx_n     = '0;
                timer_n   = '0;
                estado_n  = MOSTRA;
            end
            default: begin
                estado_n = INICIAL;
            end
        endcase
    end

    // LED register is loaded from the next state so the display lines up
    // exactly with the MOSTRA cycles; bypass covers mem[0] written in PREPARA.
    always_comb begin
        if (mem_we && (mem_waddr == RW'(idx_n))) begin
            mem_rd_n = novo_elemento;
        end else begin
            mem_rd_n = mem[RW'(idx_n)];
        end
        case (estado_n)
            MOSTRA:                             leds_n = N_BOTOES'(onehot(4'(mem_rd_n)));
            ESPERA, REGISTRA, COMPARA, PROXIMO: leds_n = chaves;
            default:                            leds_n = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIAL;
            rodada    <= '0;
            idx       <= '0;
            timer     <= '0;
            lfsr      <= SEMENTE;
            nj_q      <= 1'b0;
            nt_q      <= 1'b0;
            jogada_q  <= '0;
            ok_q      <= 1'b0;
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
            timeout_q <= 1'b0;
            leds_q    <= '0;
            for (int i = 0; i < MAX_RODADAS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            estado    <= estado_n;
            rodada    <= rodada_n;
            idx       <= idx_n;
            timer     <= timer_n;
            lfsr      <= lfsr_passo(lfsr);
            nj_q      <= nj_n;
            nt_q      <= nt_n;
            jogada_q  <= jogada_n;
            ok_q      <= ok_n;
            acertou_q <= acertou_n;
            errou_q   <= errou_n;
            timeout_q <= timeout_n;
            leds_q    <= leds_n;
            if (mem_we) begin
                mem[mem_waddr] <= novo_elemento;
            end
        end
    end

    assign leds        = leds_q;
    assign acertou     = acertou_q;
    assign errou       = errou_q;
    assign timeout     = timeout_q;
    assign pronto      = (estado == FIM_ACERTO) || (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
    assign db_estado   = estado;
    assign db_rodada   = rodada;
    assign db_contagem = idx;
    assign db_jogada   = jogada_q;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// tb/tb_jogo_sequencia_param.sv - directed self-checking bench for jogo_sequencia_param
module tb_jogo_sequencia_param;

    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int TOUT = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] chaves = 4'b0;
    logic       nivel_jogadas = 1'b0;
    logic       nivel_tempo = 1'b0;
    logic [3:0] leds;
    logic       acertou, errou, timeout, pronto;
    logic [3:0] db_estado;
    logic [5:0] db_rodada, db_contagem;
    logic [1:0] db_jogada;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_lfsr;
    logic [1:0] seq [0:3];

    jogo_sequencia_param #(
        .N_BOTOES       (4),
        .MAX_RODADAS    (4),
        .TIMEOUT_CICLOS (TOUT),
        .SHOW_CICLOS    (SHOW),
        .GAP_CICLOS     (GAP),
        .SEMENTE        (8'hA5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .chaves        (chaves),
        .nivel_jogadas (nivel_jogadas),
        .nivel_tempo   (nivel_tempo),
        .leds          (leds),
        .acertou       (acertou),
        .errou         (errou),
        .timeout       (timeout),
        .pronto        (pronto),
        .db_estado     (db_estado),
        .db_rodada     (db_rodada),
        .db_contagem   (db_contagem),
        .db_jogada     (db_jogada)
    );

    always #5 clock = ~clock;

    // Reference LFSR for x^8+x^6+x^5+x^4+1, seeded with A5 and stepping every cycle.
    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [3:0] oh(input logic [1:0] k);
        logic [3:0] one;
        one = 4'b0001;
        return one << k;
    endfunction

    // Ends at a negedge inside PREPARA; seq[0] is the LFSR value seen in that cycle.
    task automatic start_game(input logic nj, input logic nt);
        @(negedge clock);
        iniciar = 1'b1; nivel_jogadas = nj; nivel_tempo = nt;
        @(posedge clock); #1;
        seq[0] = m_lfsr[1:0];
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // Called from a negedge in the cycle before MOSTRA; ends 1 unit after ESPERA entry.
    task automatic play_round(input int r);
        logic       bad_on, bad_off;
        logic [3:0] seen_on, seen_off;
        for (int e = 0; e <= r; e++) begin
            bad_on = 1'b0; bad_off = 1'b0; seen_on = '0; seen_off = '0;
            for (int c = 0; c < SHOW; c++) begin
                @(negedge clock);
                if (leds !== oh(seq[e])) begin bad_on = 1'b1; seen_on = leds; end
            end
            for (int c = 0; c < GAP; c++) begin
                @(negedge clock);
                if (leds !== 4'b0) begin bad_off = 1'b1; seen_off = leds; end
            end
            n_vec++;
            if (bad_on) begin
                n_err++;
                $display("FAIL show_r%0d_e%0d leds=%b expected=%b", r, e, seen_on, oh(seq[e]));
            end
            n_vec++;
            if (bad_off) begin
                n_err++;
                $display("FAIL gap_r%0d_e%0d leds=%b expected=0000", r, e, seen_off);
            end
        end
        @(posedge clock); #1;
        n_vec++;
        if (db_estado !== 4'h4) begin
            n_err++;
            $display("FAIL espera_after_r%0d db_estado=%h expected=4", r, db_estado);
        end
    endtask

    // Must start while in ESPERA; ends 1 unit after the verdict edge.
    task automatic press(input logic [3:0] vec);
        @(negedge clock); chaves = vec;
        @(posedge clock);
        @(negedge clock); chaves = 4'b0;
        @(posedge clock);
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_vec++;
        if (db_estado !== 4'h0 || leds !== 4'b0) begin
            n_err++;
            $display("FAIL reset_state db_estado=%h leds=%b expected=0 0000", db_estado, leds);
        end
        n_vec++;
        if ({acertou, errou, timeout, pronto} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags flags=%b expected=0000", {acertou, errou, timeout, pronto});
        end
        n_vec++;
        if (db_rodada !== 6'd0 || db_contagem !== 6'd0 || db_jogada !== 2'd0) begin
            n_err++;
            $display("FAIL reset_debug rodada=%0d contagem=%0d jogada=%0d expected=0 0 0",
                     db_rodada, db_contagem, db_jogada);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_win;
        start_game(1'b0, 1'b0);
        play_round(0);
        press(oh(seq[0]));
        n_vec++;
        if (db_estado !== 4'h8) begin
            n_err++;
            $display("FAIL win_nova_rodada db_estado=%h expected=8", db_estado);
        end
        seq[1] = m_lfsr[1:0];
        @(negedge clock);
        play_round(1);
        n_vec++;
        if (db_rodada !== 6'd1) begin
            n_err++;
            $display("FAIL win_rodada db_rodada=%0d expected=1", db_rodada);
        end
        press(oh(seq[0]));
        n_vec++;
        if (db_estado !== 4'h7) begin
            n_err++;
            $display("FAIL win_proximo db_estado=%h expected=7", db_estado);
        end
        @(posedge clock); #1;
        n_vec++;
        if (db_estado !== 4'h4 || db_contagem !== 6'd1) begin
            n_err++;
            $display("FAIL win_idx db_estado=%h contagem=%0d expected=4 1", db_estado, db_contagem);
        end
        press(oh(seq[1]));
        n_vec++;
        if (db_estado !== 4'hA || acertou !== 1'b1 || pronto !== 1'b1 || errou !== 1'b0) begin
            n_err++;
            $display("FAIL win_final db_estado=%h acertou=%b pronto=%b errou=%b expected=A 1 1 0",
                     db_estado, acertou, pronto, errou);
        end
    endtask

    task automatic test_error;
        logic [1:0] wrong;
        start_game(1'b0, 1'b0);
        play_round(0);
        n_vec++;
        if (acertou !== 1'b0 || pronto !== 1'b0) begin
            n_err++;
            $display("FAIL error_restart_clear acertou=%b pronto=%b expected=0 0", acertou, pronto);
        end
        wrong = seq[0] + 2'd1;
        @(negedge clock); chaves = oh(wrong);
        @(posedge clock); #1;
        n_vec++;
        if (db_estado !== 4'h5 || db_jogada !== wrong) begin
            n_err++;
            $display("FAIL error_registra db_estado=%h jogada=%0d expected=5 %0d", db_estado, db_jogada, wrong);
        end
        @(negedge clock); chaves = 4'b0;
        @(posedge clock); #1;
        n_vec++;
        if (db_estado !== 4'h6 || errou !== 1'b0) begin
            n_err++;
            $display("FAIL error_compara db_estado=%h errou=%b expected=6 0", db_estado, errou);
        end
        @(posedge clock); #1;
        n_vec++;
        if (db_estado !== 4'hE || errou !== 1'b1 || pronto !== 1'b1) begin
            n_err++;
            $display("FAIL error_final db_estado=%h errou=%b pronto=%b expected=E 1 1", db_estado, errou, pronto);
        end
    endtask

    task automatic test_timeout_fast;
        start_game(1'b0, 1'b1);
        play_round(0);
        repeat (TOUT / 2 - 1) @(posedge clock);
        #1;
        n_vec++;
        if (db_estado !== 4'h4 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL tfast_early db_estado=%h timeout=%b expected=4 0", db_estado, timeout);
        end
        @(posedge clock); #1;
        n_vec++;
        if (db_estado !== 4'hF || timeout !== 1'b1 || pronto !== 1'b1 || errou !== 1'b0) begin
            n_err++;
            $display("FAIL tfast_fire db_estado=%h timeout=%b pronto=%b errou=%b expected=F 1 1 0",
                     db_estado, timeout, pronto, errou);
        end
    endtask

    task automatic test_timeout_slow;
        start_game(1'b0, 1'b0);
        play_round(0);
        nivel_tempo = 1'b1;
        repeat (TOUT / 2) @(posedge clock);
        #1;
        n_vec++;
        if (db_estado !== 4'h4 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL tslow_half db_estado=%h timeout=%b expected=4 0", db_estado, timeout);
        end
        repeat (TOUT / 2 - 1) @(posedge clock);
        #1;
        n_vec++;
        if (db_estado !== 4'h4) begin
            n_err++;
            $display("FAIL tslow_last db_estado=%h expected=4", db_estado);
        end
        @(posedge clock); #1;
        n_vec++;
        if (db_estado !== 4'hF || timeout !== 1'b1) begin
            n_err++;
            $display("FAIL tslow_fire db_estado=%h timeout=%b expected=F 1", db_estado, timeout);
        end
        nivel_tempo = 1'b0;
    endtask

    task automatic test_invalid;
        start_game(1'b0, 1'b0);
        play_round(0);
        n_vec++;
        if (timeout !== 1'b0) begin
            n_err++;
            $display("FAIL invalid_restart_clear timeout=%b expected=0", timeout);
        end
        press(4'b0011);
        n_vec++;
        if (db_estado !== 4'hE || errou !== 1'b1) begin
            n_err++;
            $display("FAIL invalid_press db_estado=%h errou=%b expected=E 1", db_estado, errou);
        end
    endtask

    task automatic test_held_key;
        start_game(1'b0, 1'b0);
        chaves = oh(seq[0]);
        play_round(0);
        n_vec++;
        if (leds !== oh(seq[0])) begin
            n_err++;
            $display("FAIL held_mirror leds=%b expected=%b", leds, oh(seq[0]));
        end
        repeat (3) @(posedge clock);
        #1;
        n_vec++;
        if (db_estado !== 4'h4) begin
            n_err++;
            $display("FAIL held_no_press db_estado=%h expected=4", db_estado);
        end
        @(negedge clock); chaves = 4'b0;
        press(oh(seq[0]));
        n_vec++;
        if (db_estado !== 4'h8) begin
            n_err++;
            $display("FAIL held_then_press db_estado=%h expected=8", db_estado);
        end
    endtask

    task automatic test_reset_midgame;
        @(posedge clock); #1;
        n_vec++;
        if (db_estado !== 4'h2 || leds !== oh(seq[0])) begin
            n_err++;
            $display("FAIL mid_mostra db_estado=%h leds=%b expected=2 %b", db_estado, leds, oh(seq[0]));
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (db_estado !== 4'h0 || leds !== 4'b0 || db_rodada !== 6'd0) begin
            n_err++;
            $display("FAIL mid_async_reset db_estado=%h leds=%b rodada=%0d expected=0 0000 0",
                     db_estado, leds, db_rodada);
        end
        @(negedge clock);
        reset = 1'b1;
        start_game(1'b0, 1'b0);
        n_vec++;
        if (db_estado !== 4'h1 || db_rodada !== 6'd0) begin
            n_err++;
            $display("FAIL mid_restart db_estado=%h rodada=%0d expected=1 0", db_estado, db_rodada);
        end
        play_round(0);
    endtask

    initial begin
        test_reset;
        test_win;
        test_error;
        test_timeout_fast;
        test_timeout_slow;
        test_invalid;
        test_held_key;
        test_reset_midgame;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
